// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic MIPS32 inter-stage register carrying a payload and a
// valid bit, resolving advance / hold / bubble / flush from the core stall
// vector and a flush strobe.
// Optional feature macro: PIPE_STAGE_PERF_CNT_EN builds saturating stall,
// bubble and flush counters. Without it the counter outputs read 0 and
// clr_cnt is ignored.
module pipe_stage_reg #(
   parameter int unsigned          DATA_W    = 32,
   parameter int unsigned          STALL_W   = 6,
   parameter int unsigned          STAGE     = 3,
   parameter logic [DATA_W-1:0]    NOP_VALUE = '0,
   parameter int unsigned          CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [STALL_W-1:0]   stall,
   input  logic                 flush,
   input  logic [DATA_W-1:0]    data_i,
   input  logic                 valid_i,
   output logic [DATA_W-1:0]    data_o,
   output logic                 valid_o,
   output logic                 hold_o,
   input  logic                 clr_cnt,
   output logic [CNT_W-1:0]     stall_cnt_o,
   output logic [CNT_W-1:0]     bubble_cnt_o,
   output logic [CNT_W-1:0]     flush_cnt_o
);

   logic stall_self;
   logic nxt;

   // The top stage has no downstream stall bit, so it can never hold.
   generate
      if (STAGE == STALL_W - 1) begin : g_top_stage
         assign nxt = 1'b0;
      end else begin : g_mid_stage
         assign nxt = stall[STAGE+1];
      end
   endgenerate

   assign stall_self = stall[STAGE];

   // Only two stall bits matter; the rest are consumed here to keep lint quiet.
   logic unused_stall;
   assign unused_stall = &{1'b0, stall};

   logic do_flush;
   logic do_bubble;
   logic do_hold;

   assign do_flush  = ~rst & flush;
   assign do_bubble = ~rst & ~flush & stall_self & ~nxt;
   assign do_hold   = ~rst & ~flush & stall_self & nxt;
   assign hold_o    = do_hold;

   logic [DATA_W-1:0] data_d,  data_q;
   logic              valid_d, valid_q;

   // Next payload/valid: reset, flush and bubble all load a NOP; hold keeps.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (rst || flush || do_bubble) begin
         data_d  = NOP_VALUE;
         valid_d = 1'b0;
      end else if (!stall_self) begin
         data_d  = data_i;
         valid_d = valid_i;
      end
   end

   // Stage register.
   always_ff @(posedge clk) begin
      data_q  <= data_d;
      valid_q <= valid_d;
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] stall_cnt_d,  stall_cnt_q;
   logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d,  flush_cnt_q;

   // Saturating event counters; clr_cnt wins over a coincident event.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (rst || clr_cnt) begin
         stall_cnt_d  = '0;
         bubble_cnt_d = '0;
         flush_cnt_d  = '0;
      end else begin
         if (do_hold && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (do_bubble && bubble_cnt_q != CNT_MAX)
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
         if (do_flush && flush_cnt_q != CNT_MAX)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
   end

   assign stall_cnt_o  = stall_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
   assign flush_cnt_o  = flush_cnt_q;
`else
   logic unused_clr;
   assign unused_clr   = &{1'b0, clr_cnt};
   assign stall_cnt_o  = '0;
   assign bubble_cnt_o = '0;
   assign flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a mid stage (STAGE=3), a top stage
// (STAGE=5) and a mid stage with 3-bit counters for saturation/clear.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_i;
   logic        valid_i;

   logic [5:0]  stall_m, stall_t, stall_s;
   logic        flush_m, flush_t, flush_s;
   logic        clr_m,   clr_t,   clr_s;

   logic [31:0] data_m, data_t, data_s;
   logic        valid_m, valid_t, valid_s;
   logic        hold_m, hold_t, hold_s;
   logic [31:0] scnt_m, bcnt_m, fcnt_m;
   logic [31:0] scnt_t, bcnt_t, fcnt_t;
   logic [2:0]  scnt_s, bcnt_s, fcnt_s;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(3), .NOP_VALUE(32'h0), .CNT_W(32)) u_main (
      .clk(clk), .rst(rst), .stall(stall_m), .flush(flush_m),
      .data_i(data_i), .valid_i(valid_i),
      .data_o(data_m), .valid_o(valid_m), .hold_o(hold_m),
      .clr_cnt(clr_m), .stall_cnt_o(scnt_m), .bubble_cnt_o(bcnt_m), .flush_cnt_o(fcnt_m));

   pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(5), .NOP_VALUE(32'h0), .CNT_W(32)) u_top (
      .clk(clk), .rst(rst), .stall(stall_t), .flush(flush_t),
      .data_i(data_i), .valid_i(valid_i),
      .data_o(data_t), .valid_o(valid_t), .hold_o(hold_t),
      .clr_cnt(clr_t), .stall_cnt_o(scnt_t), .bubble_cnt_o(bcnt_t), .flush_cnt_o(fcnt_t));

   pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(3), .NOP_VALUE(32'h0), .CNT_W(3)) u_sat (
      .clk(clk), .rst(rst), .stall(stall_s), .flush(flush_s),
      .data_i(data_i), .valid_i(valid_i),
      .data_o(data_s), .valid_o(valid_s), .hold_o(hold_s),
      .clr_cnt(clr_s), .stall_cnt_o(scnt_s), .bubble_cnt_o(bcnt_s), .flush_cnt_o(fcnt_s));

   // Expected counter value: the counters only exist in the perf build.
   function automatic logic [63:0] cx(input logic [63:0] v);
`ifdef PIPE_STAGE_PERF_CNT_EN
      return v;
`else
      return 64'd0 & v;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; data_i = 32'hDEADBEEF; valid_i = 1'b1;
      stall_m = '0; stall_t = '0; stall_s = '0;
      flush_m = 0; flush_t = 0; flush_s = 0;
      clr_m = 0; clr_t = 0; clr_s = 0;
      #2;
      tick(2);
      // Reset state
      check("rst_data",   data_m,  32'h0);
      check("rst_valid",  valid_m, 1'b0);
      check("rst_hold",   hold_m,  1'b0);
      check("rst_scnt",   scnt_m,  cx(0));
      check("rst_bcnt",   bcnt_m,  cx(0));
      check("rst_fcnt",   fcnt_m,  cx(0));
      rst = 1'b0;
      tick();
      check("post_rst_data",  data_m,  32'hDEADBEEF);
      check("post_rst_valid", valid_m, 1'b1);

      // Hold then release
      data_i = 32'h00400010;
      tick();
      check("load_data", data_m, 32'h00400010);
      stall_m = 6'b011000; stall_t = 6'b100000; data_i = 32'h11111111;
      #1;
      check("hold_o_on", hold_m, 1'b1);
      check("top_hold_o_off", hold_t, 1'b0);
      tick(2);
      stall_t = 6'b111111;
      #1;
      check("top_hold_o_all", hold_t, 1'b0);
      tick(3);
      check("hold_data",  data_m,  32'h00400010);
      check("hold_valid", valid_m, 1'b1);
      check("hold_scnt",  scnt_m,  cx(5));
      check("top_data",   data_t,  32'h0);
      check("top_valid",  valid_t, 1'b0);
      check("top_bcnt",   bcnt_t,  cx(5));
      check("top_scnt",   scnt_t,  cx(0));
      stall_m = 6'b0; stall_t = 6'b0; data_i = 32'h00400014;
      tick();
      check("release_data", data_m, 32'h00400014);
      check("release_scnt", scnt_m, cx(5));
      check("top_release",  data_t, 32'h00400014);

      // Bubble
      stall_m = 6'b001000; data_i = 32'h00400018;
      #1;
      check("bubble_hold_o", hold_m, 1'b0);
      tick();
      check("bubble_data",  data_m,  32'h0);
      check("bubble_valid", valid_m, 1'b0);
      check("bubble_bcnt",  bcnt_m,  cx(1));
      stall_m = 6'b0; data_i = 32'h0040001C;
      tick();
      check("after_bubble_data",  data_m,  32'h0040001C);
      check("after_bubble_valid", valid_m, 1'b1);

      // Flush during hold
      stall_m = 6'b011000;
      tick();
      check("pre_flush_scnt", scnt_m, cx(6));
      flush_m = 1'b1;
      #1;
      check("flush_hold_o", hold_m, 1'b0);
      tick();
      check("flush_data",  data_m,  32'h0);
      check("flush_valid", valid_m, 1'b0);
      check("flush_fcnt",  fcnt_m,  cx(1));
      check("flush_scnt",  scnt_m,  cx(6));
      flush_m = 1'b0;
      tick();
      check("post_flush_hold_scnt", scnt_m, cx(7));
      check("post_flush_hold_data", data_m, 32'h0);

      // Invalid payload passes through untouched; unrelated stall bits ignored
      stall_m = 6'b100111; data_i = 32'h12345678; valid_i = 1'b0;
      #1;
      check("ignored_bits_hold_o", hold_m, 1'b0);
      tick();
      check("inv_data",  data_m,  32'h12345678);
      check("inv_valid", valid_m, 1'b0);

      // Flush coinciding with a bubble counts as flush only
      stall_m = 6'b001000; flush_m = 1'b1; valid_i = 1'b1; data_i = 32'hCAFEF00D;
      tick();
      check("fb_fcnt", fcnt_m, cx(2));
      check("fb_bcnt", bcnt_m, cx(1));
      check("fb_data", data_m, 32'h0);
      flush_m = 1'b0;

      // Reset asserted mid-hold
      stall_m = 6'b0; data_i = 32'hA5A5A5A5;
      tick();
      check("pre_rst_data", data_m, 32'hA5A5A5A5);
      stall_m = 6'b011000;
      tick();
      check("pre_rst_scnt", scnt_m, cx(8));
      rst = 1'b1;
      #1;
      check("rst_hold_o", hold_m, 1'b0);
      tick();
      check("midrst_data",  data_m,  32'h0);
      check("midrst_valid", valid_m, 1'b0);
      check("midrst_scnt",  scnt_m,  cx(0));
      check("midrst_fcnt",  fcnt_m,  cx(0));
      check("midrst_bcnt",  bcnt_m,  cx(0));
      rst = 1'b0;

      // Clear coinciding with a hold
      tick();
      check("clr_pre_scnt", scnt_m, cx(1));
      clr_m = 1'b1;
      tick();
      check("clr_scnt", scnt_m, cx(0));
      clr_m = 1'b0;
      stall_m = 6'b0;

      // Saturation on the 3-bit counter instance
      data_i = 32'h0BADC0DE;
      tick();
      check("sat_load", data_s, 32'h0BADC0DE);
      stall_s = 6'b011000; data_i = 32'h0;
      tick(7);
      check("sat_scnt7", scnt_s, cx(7));
      tick(3);
      check("sat_scnt10", scnt_s, cx(7));
      check("sat_data",   data_s, 32'h0BADC0DE);
      clr_s = 1'b1;
      tick();
      check("sat_clr", scnt_s, cx(0));
      clr_s = 1'b0;
      tick();
      check("sat_after_clr", scnt_s, cx(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
